// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the IF-stage branch predictor: 2-bit counter states,
// the unresolved-NPC marker and saturating counter helpers.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    localparam logic [31:0] NPC_UNRESOLVED = 32'hFFFF_FFFF;

    function automatic bp_ctr_e ctr_inc(input bp_ctr_e c);
        bp_ctr_e n;
        n = BP_ST;
        case (c)
            BP_SNT:  n = BP_WNT;
            BP_WNT:  n = BP_WT;
            default: n = BP_ST;
        endcase
        return n;
    endfunction

    function automatic bp_ctr_e ctr_dec(input bp_ctr_e c);
        bp_ctr_e n;
        n = BP_SNT;
        case (c)
            BP_ST:   n = BP_WT;
            BP_WT:   n = BP_WNT;
            default: n = BP_SNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped BTB storage: asynchronous read for the IF lookup, an update-side
// read of valid/tag/ctr for the ID resolve, and one synchronous write port.
module btb_array
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output bp_ctr_e          rd_ctr,
    output logic [31:0]      rd_target,
    input  logic [IDX_W-1:0] upd_idx,
    output logic             upd_valid,
    output logic [TAG_W-1:0] upd_tag,
    output bp_ctr_e          upd_ctr,
    input  logic             wr_en,
    input  logic             wr_tgt_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  bp_ctr_e          wr_ctr,
    input  logic [31:0]      wr_target
);

    localparam int DEPTH = 1 << IDX_W;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    bp_ctr_e          ctr_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    assign upd_valid = valid_q[upd_idx];
    assign upd_tag   = tag_q[upd_idx];
    assign upd_ctr   = ctr_q[upd_idx];

    // Every write leaves the entry valid; the target is kept on not-taken updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= BP_WNT;
                target_q[i] <= '0;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= wr_tag;
            ctr_q[upd_idx]   <= wr_ctr;
            if (wr_tgt_en) begin
                target_q[upd_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: BTB lookup, 2-bit counter training from
// branches resolved in ID, the IF/ID prediction register and branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] IFPC,
    output logic [31:0] NPC_Predict,
    output logic        PredTaken,
    input  logic        IFIDWr,
    input  logic        IFIDRst,
    output logic [31:0] IFIDNPC_Predict,
    input  logic [31:0] IFIDPC,
    input  logic        BrValid,
    input  logic [31:0] IFIDNPC,
    output logic [31:0] BrCnt,
    output logic [31:0] MissCnt
);

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_valid;
    logic [TAG_W-1:0] lk_stored_tag;
    bp_ctr_e          lk_ctr;
    logic [31:0]      lk_target;
    logic             lk_hit;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_valid;
    logic [TAG_W-1:0] up_stored_tag;
    bp_ctr_e          up_ctr;
    logic             up_hit;
    logic             upd_en;
    logic             br_taken;

    logic             wr_en;
    bp_ctr_e          wr_ctr;

    assign lk_idx = IFPC[IDX_W+1:2];
    assign lk_tag = IFPC[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = IFIDPC[IDX_W+1:2];
    assign up_tag = IFIDPC[IDX_W+TAG_W+1:IDX_W+2];

    btb_array #(
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_btb (
        .clk       (clk),
        .rstn      (rstn),
        .rd_idx    (lk_idx),
        .rd_valid  (lk_valid),
        .rd_tag    (lk_stored_tag),
        .rd_ctr    (lk_ctr),
        .rd_target (lk_target),
        .upd_idx   (up_idx),
        .upd_valid (up_valid),
        .upd_tag   (up_stored_tag),
        .upd_ctr   (up_ctr),
        .wr_en     (wr_en),
        .wr_tgt_en (br_taken),
        .wr_tag    (up_tag),
        .wr_ctr    (wr_ctr),
        .wr_target (IFIDNPC)
    );

    assign lk_hit      = lk_valid && (lk_stored_tag == lk_tag);
    assign PredTaken   = lk_hit && ((lk_ctr == BP_WT) || (lk_ctr == BP_ST));
    assign NPC_Predict = PredTaken ? lk_target : (IFPC + 32'd4);

    assign up_hit   = up_valid && (up_stored_tag == up_tag);
    assign upd_en   = BrValid && (IFIDNPC != NPC_UNRESOLVED);
    assign br_taken = (IFIDNPC != (IFIDPC + 32'd4));

    // A miss is only allocated when taken; not-taken misses leave the table alone.
    always_comb begin
        wr_en  = 1'b0;
        wr_ctr = BP_WT;
        if (upd_en) begin
            if (up_hit) begin
                wr_en  = 1'b1;
                wr_ctr = br_taken ? ctr_inc(up_ctr) : ctr_dec(up_ctr);
            end else if (br_taken) begin
                wr_en  = 1'b1;
                wr_ctr = BP_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            IFIDNPC_Predict <= '0;
        end else if (IFIDRst) begin
            IFIDNPC_Predict <= '0;
        end else if (IFIDWr) begin
            IFIDNPC_Predict <= NPC_Predict;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            BrCnt   <= '0;
            MissCnt <= '0;
        end else if (upd_en) begin
            BrCnt <= BrCnt + 32'd1;
            if (IFIDNPC_Predict != IFIDNPC) begin
                MissCnt <= MissCnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus queues expected values, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_branch_predictor;

    localparam int SEL_NPC    = 0;
    localparam int SEL_TAKEN  = 1;
    localparam int SEL_IFIDP  = 2;
    localparam int SEL_BRCNT  = 3;
    localparam int SEL_MISS   = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] expv;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [31:0] IFPC;
    logic [31:0] NPC_Predict;
    logic        PredTaken;
    logic        IFIDWr;
    logic        IFIDRst;
    logic [31:0] IFIDNPC_Predict;
    logic [31:0] IFIDPC;
    logic        BrValid;
    logic [31:0] IFIDNPC;
    logic [31:0] BrCnt;
    logic [31:0] MissCnt;

    exp_t expQ[$];
    exp_t cur;
    int   compared   = 0;
    int   mismatched = 0;

    branch_predictor #(
        .IDX_W(6),
        .TAG_W(8)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .IFPC            (IFPC),
        .NPC_Predict     (NPC_Predict),
        .PredTaken       (PredTaken),
        .IFIDWr          (IFIDWr),
        .IFIDRst         (IFIDRst),
        .IFIDNPC_Predict (IFIDNPC_Predict),
        .IFIDPC          (IFIDPC),
        .BrValid         (BrValid),
        .IFIDNPC         (IFIDNPC),
        .BrCnt           (BrCnt),
        .MissCnt         (MissCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] getActual(input int sel);
        logic [31:0] v;
        v = 32'h0;
        case (sel)
            SEL_NPC:   v = NPC_Predict;
            SEL_TAKEN: v = {31'h0, PredTaken};
            SEL_IFIDP: v = IFIDNPC_Predict;
            SEL_BRCNT: v = BrCnt;
            SEL_MISS:  v = MissCnt;
            default:   v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: everything queued during a cycle is compared at its falling edge
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            cur = expQ.pop_front();
            compared++;
            if (getActual(cur.sel) !== cur.expv) begin
                mismatched++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                         cur.name, getActual(cur.sel), cur.expv, $time);
            end
        end
    end

    task automatic checkOutput(input string name, input int sel, input logic [31:0] expv);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.expv = expv;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] ifpc, input logic wr, input logic rst,
                                 input logic [31:0] idpc, input logic brv,
                                 input logic [31:0] idnpc);
        IFPC    = ifpc;
        IFIDWr  = wr;
        IFIDRst = rst;
        IFIDPC  = idpc;
        BrValid = brv;
        IFIDNPC = idnpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch pc into IF/ID, then resolve it in ID to npc; expPred is the lookup
    // result before the update, also seen during the resolve cycle (no bypass).
    task automatic branchStep(input logic [31:0] pc, input logic [31:0] npc,
                              input logic [31:0] expPred);
        applyStimulus(pc, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("fetch_pred", SEL_NPC, expPred);
        tick();
        applyStimulus(pc, 1'b0, 1'b0, pc, 1'b1, npc);
        checkOutput("ifid_pred", SEL_IFIDP, expPred);
        checkOutput("same_cycle_old_entry", SEL_NPC, expPred);
        tick();
        applyStimulus(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic statsCheck(input logic [31:0] br, input logic [31:0] miss);
        checkOutput("BrCnt", SEL_BRCNT, br);
        checkOutput("MissCnt", SEL_MISS, miss);
    endtask

    task automatic lookupCheck(input logic [31:0] pc, input logic [31:0] npc, input logic taken);
        applyStimulus(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("lookup_npc", SEL_NPC, npc);
        checkOutput("lookup_taken", SEL_TAKEN, {31'h0, taken});
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(32'h0000_3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rstn = 1'b1;

        checkOutput("rst_npc", SEL_NPC, 32'h0000_3004);
        checkOutput("rst_taken", SEL_TAKEN, 32'h0);
        checkOutput("rst_ifid_pred", SEL_IFIDP, 32'h0);
        statsCheck(32'd0, 32'd0);
        tick();

        // Allocation, saturation up, decay down to weak-not-taken
        branchStep(32'h40, 32'h80, 32'h44);  statsCheck(32'd1, 32'd1); lookupCheck(32'h40, 32'h80, 1'b1);
        branchStep(32'h40, 32'h80, 32'h80);  statsCheck(32'd2, 32'd1); lookupCheck(32'h40, 32'h80, 1'b1);
        branchStep(32'h40, 32'h80, 32'h80);  statsCheck(32'd3, 32'd1); lookupCheck(32'h40, 32'h80, 1'b1);
        branchStep(32'h40, 32'h44, 32'h80);  statsCheck(32'd4, 32'd2); lookupCheck(32'h40, 32'h80, 1'b1);
        branchStep(32'h40, 32'h44, 32'h80);  statsCheck(32'd5, 32'd3); lookupCheck(32'h40, 32'h44, 1'b0);

        // Aliasing entries share index 16; the later allocation evicts the earlier
        branchStep(32'h40, 32'h80, 32'h44);   statsCheck(32'd6, 32'd4); lookupCheck(32'h40, 32'h80, 1'b1);
        branchStep(32'h140, 32'h200, 32'h144); statsCheck(32'd7, 32'd5);
        lookupCheck(32'h40, 32'h44, 1'b0);
        lookupCheck(32'h140, 32'h200, 1'b1);

        // Not-taken miss leaves the table untouched
        branchStep(32'h80, 32'h84, 32'h84);  statsCheck(32'd8, 32'd5); lookupCheck(32'h80, 32'h84, 1'b0);

        // Hold for three cycles, then flush with load also requested
        applyStimulus(32'h140, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("hold_ifid_pred", SEL_IFIDP, 32'h200);
            tick();
        end
        applyStimulus(32'h3000, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(32'h3000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("flush_ifid_pred", SEL_IFIDP, 32'h0);
        tick();

        // Unresolved NPC must not train or count
        applyStimulus(32'h3000, 1'b0, 1'b0, 32'h140, 1'b1, 32'hFFFF_FFFF);
        tick();
        statsCheck(32'd8, 32'd5);
        lookupCheck(32'h140, 32'h200, 1'b1);

        branchStep(32'h140, 32'h200, 32'h200); statsCheck(32'd9, 32'd5);
        branchStep(32'hC0, 32'h10, 32'hC4);    statsCheck(32'd10, 32'd6);
        lookupCheck(32'hC0, 32'h10, 1'b1);

        // Asynchronous reset mid-stream, checked before any further clock edge
        applyStimulus(32'hC0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        applyStimulus(32'hC0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("pre_rst_ifid_pred", SEL_IFIDP, 32'h10);
        statsCheck(32'd10, 32'd6);
        tick();
        #2;
        rstn = 1'b0;
        checkOutput("async_rst_npc", SEL_NPC, 32'hC4);
        checkOutput("async_rst_taken", SEL_TAKEN, 32'h0);
        checkOutput("async_rst_ifid_pred", SEL_IFIDP, 32'h0);
        statsCheck(32'd0, 32'd0);
        tick();
        rstn = 1'b1;
        lookupCheck(32'h140, 32'h144, 1'b0);
        lookupCheck(32'h40, 32'h44, 1'b0);

        tick();
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d checks pending, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage dynamic branch predictor for the 5-stage pipeline: a direct-mapped branch target buffer with 2-bit saturating counters. It supplies the predicted next PC to the PC mux and carries that prediction alongside the fetched instruction, as IFIDNPC_Predict, into the hazard/forwarding unit. It learns from branches resolved in ID and keeps branch and mispredict statistics.

## Interface
- IDX_W, 6: BTB index width (2^IDX_W entries).
- TAG_W, 8: stored tag width.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- IFPC  in  32  PC of the instruction being fetched.
- NPC_Predict  out  32  combinational predicted next PC for the PC mux.
- PredTaken  out  1  combinational: current lookup predicts taken.
- IFIDWr  in  1  IF/ID write enable from hazard unit (0 = hold).
- IFIDRst  in  1  IF/ID flush from hazard unit.
- IFIDNPC_Predict  out  32  registered prediction travelling with the IF/ID instruction.
- IFIDPC  in  32  PC of the instruction in ID.
- BrValid  in  1  conditional branch in ID whose outcome is resolved this cycle (branch op && !IDEXRst).
- IFIDNPC  in  32  resolved next PC from NPC; 32'hFFFF_FFFF = unresolved.
- BrCnt  out  32  resolved-branch counter.
- MissCnt  out  32  mispredict counter.

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2].
- Entry = {valid, tag, ctr[1:0], target[31:0]}. Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational on IFPC):
  - hit = valid && tag match.
  - PredTaken = hit && ctr[1].
  - NPC_Predict = target when PredTaken, else IFPC+4 (32-bit wrap).
- IFIDNPC_Predict register, with priority IFIDRst > hold > load:
  - IFIDRst=1: loads 0.
  - else IFIDWr=0: holds.
  - else: loads NPC_Predict.
- Update is enabled when BrValid && IFIDNPC != 32'hFFFF_FFFF. Resolved taken = (IFIDNPC != IFIDPC+4). Entry is addressed by IFIDPC.
  - Hit, taken: ctr saturating +1 (11 stays 11); target <= IFIDNPC.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate, overwriting any entry: valid=1, tag, ctr=10, target=IFIDNPC.
  - Miss, not taken: no change.
- Statistics, on every enabled update:
  - BrCnt += 1.
  - MissCnt += 1 when IFIDNPC_Predict != IFIDNPC.
  - Both wrap modulo 2^32.
- Non-branch instructions never modify the BTB.

## Timing
- Lookup is zero-latency combinational. The IFIDNPC_Predict register has 1-cycle latency, aligned with the IF/ID instruction register.
- Updates commit on the rising edge after the resolve cycle.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents; no bypass.
- Stalled branch (BrValid held low by the hazard unit): no update and no counting until the cycle it resolves. Each branch is counted exactly once, because BrValid is asserted only in its resolve cycle.
- Reset, asynchronous and effective mid-operation:
  - all valid=0, all ctr=01, all targets=0;
  - IFIDNPC_Predict=0, BrCnt=0, MissCnt=0;
  - NPC_Predict = IFPC+4 while the table is empty.

## Structure
- Add to ctrl_encode_def.v: counter encodings `BP_SNT/`BP_WNT/`BP_WT/`BP_ST and the unresolved marker `NPC_UNRESOLVED (32'hFFFF_FFFF).
- Sub-module btb_array: entry storage with one asynchronous read port and one synchronous write port, with async reset clearing valid/ctr.
- Top level holds the lookup logic, counter update logic, IFIDNPC_Predict register and statistics counters.

## Test plan
- Reset, then IFPC=0x0000_3000 -> NPC_Predict=0x0000_3004, PredTaken=0, IFIDNPC_Predict=0, BrCnt=MissCnt=0.
- Branch at 0x40 resolves taken to 0x80 (IFIDNPC_Predict=0x44) -> BrCnt=1, MissCnt=1; next lookup of 0x40 gives NPC_Predict=0x80, ctr=10.
- Same branch taken twice more, then not taken twice -> ctr goes 11, 11 (saturated), 10, 01; lookup predicts 0x44 after the last update.
- Alias: PC 0x40 and PC 0x40+(4<<IDX_W) both taken -> the second allocation evicts the first; lookup of 0x40 misses and returns 0x44.
- IFIDWr=0 for 3 cycles, then IFIDRst=1 -> IFIDNPC_Predict holds its value, then becomes 0; BrValid=1 with IFIDNPC=0xFFFF_FFFF -> no table or counter change.
- Assert rstn low mid-stream after 10 updates -> all outputs and entries cleared immediately (asynchronously); same-cycle lookup/update on one index returns the old entry.
